// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer path: frame geometry and the
// scan-out fetch state encoding.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned PIXELS   = H_ACTIVE * V_ACTIVE;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } fetch_state_e;

endpackage

// File: rtl/vga_pix_fifo.sv
// Scan-out prefetch FIFO. Push with a full FIFO is accepted only alongside a pop;
// a pop on empty is ignored. Flush empties it in one cycle.
module vga_pix_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [DATA_W-1:0]      i_wdata,
    output logic [DATA_W-1:0]      o_rdata,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_empty;
    logic              w_full;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // Storage carries no reset; the count alone defines which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out prefetch into a pixel FIFO with
// urgent priority when low, round-robin between two pixel writers otherwise.
module vga_fb_arbiter #(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned PIXELS     = vga_pkg::PIXELS,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LOW_WM     = 2
) (
    input  logic              CLOCK_50,
    input  logic              ar,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underflow,
    input  logic [1:0]        wr_req,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    output logic [1:0]        wr_gnt,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import vga_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [1:0]        r_wr_gnt;
    logic              r_rr;
    logic              r_rd_valid;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_discard;
    logic              r_underflow;

    logic [CW-1:0]     w_count;
    logic [1:0]        w_req;
    logic              w_eligible;
    logic              w_urgent;
    logic              w_wr_sel;
    logic              w_do_fetch;
    logic              w_do_wr;
    logic              w_push;
    logic              w_last;

    always_comb begin
        // A writer seeing its grant this cycle has not yet dropped its request.
        w_req      = wr_req & ~r_wr_gnt;
        w_eligible = (r_state == StRun) && !frame_start &&
                     ((32'(w_count) + 32'(r_inflight)) < FIFO_DEPTH);
        w_urgent   = (32'(w_count) <= LOW_WM);
        w_wr_sel   = (w_req == 2'b11) ? r_rr : w_req[1];
        w_do_fetch = w_eligible && (w_urgent || (w_req == 2'b00));
        w_do_wr    = !w_do_fetch && (w_req != 2'b00);
        w_push     = r_rd_valid && (r_discard == '0);
        w_last     = (r_fetch_addr == ADDR_W'(PIXELS - 1));
    end

    always_ff @(posedge CLOCK_50 or posedge ar) begin
        if (ar) begin
            r_state      <= StIdle;
            r_fetch_addr <= '0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_wr_gnt     <= '0;
            r_rr         <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_inflight   <= '0;
            r_discard    <= '0;
            r_underflow  <= 1'b0;
        end else begin
            r_mem_re   <= w_do_fetch;
            r_mem_we   <= w_do_wr;
            r_wr_gnt   <= '0;
            r_rd_valid <= r_mem_re;
            r_inflight <= r_inflight + CW'(w_do_fetch) - CW'(r_rd_valid);

            if (w_do_fetch) begin
                r_mem_addr <= r_fetch_addr;
                if (w_last) r_state <= StDone;
                else        r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
            end else if (w_do_wr) begin
                r_mem_addr          <= w_wr_sel ? wr_addr1 : wr_addr0;
                r_mem_wdata         <= w_wr_sel ? wr_data1 : wr_data0;
                r_wr_gnt[w_wr_sel]  <= 1'b1;
                r_rr                <= ~w_wr_sel;
            end

            if (frame_start) begin
                r_state      <= StRun;
                r_fetch_addr <= '0;
                r_underflow  <= 1'b0;
                // The word returning this cycle is dropped by the flush itself.
                r_discard    <= r_inflight - CW'(r_rd_valid);
            end else begin
                if (r_rd_valid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
                if (pix_pop && !pix_valid)            r_underflow <= 1'b1;
            end
        end
    end

    vga_pix_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLOCK_50),
        .i_rst   (ar),
        .i_flush (frame_start),
        .i_push  (w_push),
        .i_pop   (pix_pop),
        .i_wdata (mem_rdata),
        .o_rdata (pix_data),
        .o_count (w_count)
    );

    assign pix_valid = (w_count != '0);
    assign underflow = r_underflow;
    assign wr_gnt    = r_wr_gnt;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a short frame so the end-of-frame
// behaviour is reachable; memory returns 0xA000 ^ address one cycle after mem_re.
module tb_vga_fb_arbiter;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PIX    = 20;

    logic              CLOCK_50;
    logic              ar;
    logic              frame_start;
    logic              pix_pop;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              underflow;
    logic [1:0]        wr_req;
    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;
    logic [1:0]        wr_gnt;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_addr;
    int exp_pop;
    int pop_idx;

    vga_fb_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .PIXELS     (PIX),
        .FIFO_DEPTH (8),
        .LOW_WM     (2)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .ar          (ar),
        .frame_start (frame_start),
        .pix_pop     (pix_pop),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underflow   (underflow),
        .wr_req      (wr_req),
        .wr_addr0    (wr_addr0),
        .wr_addr1    (wr_addr1),
        .wr_data0    (wr_data0),
        .wr_data1    (wr_data1),
        .wr_gnt      (wr_gnt),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        mem_rdata <= mem_re ? (16'hA000 ^ mem_addr[15:0]) : 16'hDEAD;
    end

    function automatic logic [15:0] word(input int a);
        logic [31:0] v;
        v = a;
        return 16'hA000 ^ v[15:0];
    endfunction

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        ar = 1'b1; frame_start = 1'b0; pix_pop = 1'b0; wr_req = 2'b00;
        wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
        step();
        step();

        chk("rst_mem_re",    mem_re,    0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_wr_gnt",    wr_gnt,    0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data",  pix_data,  0);
        chk("rst_underflow", underflow, 0);
        ar = 1'b0;
        step();

        // Pop while empty: sticky underflow, no fetch in IDLE.
        pix_pop = 1'b1;
        step();
        pix_pop = 1'b0;
        chk("underflow_set", underflow, 1);
        step();
        step();
        chk("underflow_sticky", underflow, 1);
        chk("idle_no_fetch",    mem_re,    0);

        // Frame start, no pops: exactly eight reads at addresses 0..7 from t+2.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("fs_underflow_clr", underflow, 0);
        chk("fs_t1_no_re",      mem_re,    0);
        step();
        for (int k = 0; k < 8; k++) begin
            chk("prefetch_re",    mem_re,    1);
            chk("prefetch_addr",  mem_addr,  k);
            chk("prefetch_valid", pix_valid, (k >= 2) ? 1 : 0);
            if (k == 2) chk("first_word", pix_data, word(0));
            step();
        end
        for (int k = 0; k < 4; k++) begin
            chk("no_overfetch", mem_re, 0);
            step();
        end

        // Both writers requesting; pops take the FIFO from 8 down to 2.
        wr_req = 2'b11;
        wr_addr0 = 19'h00100; wr_data0 = 16'h1111;
        wr_addr1 = 19'h00200; wr_data1 = 16'h2222;
        pop_idx = 0;
        for (int i = 0; i < 10; i++) begin
            pix_pop = (i < 3) || (i >= 5 && i < 8);
            if (pix_pop) begin
                chk("rr_pop_data", pix_data, word(pop_idx));
                pop_idx++;
            end
            if (i == 0) begin
                chk("rr_c0_gnt", wr_gnt, 0);
            end else if (i < 9) begin
                chk("rr_gnt",   wr_gnt,    (i % 2 == 1) ? 2'b01 : 2'b10);
                chk("rr_we",    mem_we,    1);
                chk("rr_addr",  mem_addr,  (i % 2 == 1) ? 19'h00100 : 19'h00200);
                chk("rr_wdata", mem_wdata, (i % 2 == 1) ? 16'h1111 : 16'h2222);
            end else begin
                chk("urgent_re",   mem_re,   1);
                chk("urgent_addr", mem_addr, 8);
                chk("urgent_gnt",  wr_gnt,   0);
            end
            step();
        end
        pix_pop = 1'b0;
        wr_req  = 2'b00;
        repeat (12) step();

        // Lone writer: one grant, one write, no repeat.
        wr_req = 2'b01; wr_addr0 = 19'h3ABCD; wr_data0 = 16'h5A5A;
        step();
        chk("lone_gnt",   wr_gnt,    2'b01);
        chk("lone_we",    mem_we,    1);
        chk("lone_addr",  mem_addr,  19'h3ABCD);
        chk("lone_wdata", mem_wdata, 16'h5A5A);
        wr_req = 2'b00;
        step();
        for (int k = 0; k < 3; k++) begin
            chk("lone_no_regrant", wr_gnt, 0);
            chk("lone_no_we",      mem_we, 0);
            step();
        end

        // Two pops open room for reads 14 and 15; frame start lands while both are out.
        pix_pop = 1'b1;
        chk("fl_pop0", pix_data, word(6));
        step();
        chk("fl_pop1", pix_data, word(7));
        step();
        pix_pop = 1'b0;
        chk("fl_re14",   mem_re,   1);
        chk("fl_addr14", mem_addr, 14);
        step();
        chk("fl_re15",   mem_re,   1);
        chk("fl_addr15", mem_addr, 15);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("fl_d4_valid", pix_valid, 0);
        chk("fl_d4_re",    mem_re,    0);
        step();
        chk("fl_d5_re",    mem_re,    1);
        chk("fl_d5_addr",  mem_addr,  0);
        chk("fl_d5_valid", pix_valid, 0);
        step();
        chk("fl_d6_re",    mem_re,    1);
        chk("fl_d6_addr",  mem_addr,  1);
        chk("fl_d6_valid", pix_valid, 0);
        step();

        // Drain the whole short frame; the first word must be address 0.
        exp_addr = 2;
        exp_pop  = 0;
        for (int i = 0; i < 80; i++) begin
            if (mem_re) begin
                chk("frame_addr_seq", mem_addr, exp_addr);
                exp_addr++;
            end
            if (pix_valid) begin
                chk("frame_pop_data", pix_data, word(exp_pop));
                exp_pop++;
                pix_pop = 1'b1;
            end else begin
                pix_pop = 1'b0;
            end
            step();
        end
        pix_pop = 1'b0;
        chk("reads_per_frame", exp_addr, PIX);
        chk("words_per_frame", exp_pop,  PIX);
        chk("done_underflow",  underflow, 0);
        chk("done_empty",      pix_valid, 0);

        // After the last read, writers get the port every cycle.
        wr_req = 2'b11;
        wr_addr0 = 19'h00111; wr_data0 = 16'hAAAA;
        wr_addr1 = 19'h00222; wr_data1 = 16'hBBBB;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("done_gnt",   wr_gnt, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk("done_we",    mem_we, 1);
            chk("done_no_re", mem_re, 0);
            step();
        end
        wr_req = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port framebuffer SRAM arbiter and scan-out prefetcher for the 640x480 VGA path. It shares one synchronous memory port between the display fetch stream, which fills a small pixel FIFO drained by the VGA pixel logic, and two pixel writers (drawing engine, host). Display fetch has urgent priority when the FIFO runs low. Writers are served round-robin otherwise.

## Interface
- `ADDR_W`, 19: memory word address width.
- `DATA_W`, 16: pixel word width.
- `PIXELS`, 307200: words fetched per frame (640*480).
- `FIFO_DEPTH`, 8: prefetch FIFO depth (power of 2).
- `LOW_WM`, 2: FIFO level at or below which display fetch is urgent.

Ports:
- `CLOCK_50`  in  1  sole clock; all logic on its rising edge.
- `ar`  in  1  reset, asynchronous, active-high.
- `frame_start`  in  1  one-cycle pulse: restart fetch at address 0, flush FIFO.
- `pix_pop`  in  1  consumer takes the head word this cycle.
- `pix_data`  out  DATA_W  FIFO head word.
- `pix_valid`  out  1  FIFO not empty.
- `underflow`  out  1  sticky: `pix_pop` while empty; cleared by `frame_start`.
- `wr_req`  in  2  per-writer request; held with addr/data until granted.
- `wr_addr0`, `wr_addr1`  in  ADDR_W  write addresses.
- `wr_data0`, `wr_data1`  in  DATA_W  write data.
- `wr_gnt`  out  2  one-cycle pulse; the write is on the memory port this cycle.
- `mem_re`, `mem_we`  out  1  read / write strobe; never both high.
- `mem_addr`  out  ADDR_W  registered address.
- `mem_wdata`  out  DATA_W  registered write data.
- `mem_rdata`  in  DATA_W  valid the cycle after `mem_re`.

## Operation
- FSM states:
  - IDLE: no fetch. Reset lands here.
  - RUN: fetching.
  - DONE: all PIXELS words issued; writers only.
- Transitions:
  - `frame_start` from any state goes to RUN, with `fetch_addr`=0, FIFO count=0, and underflow cleared.
  - RUN goes to DONE when the read of address PIXELS-1 issues.
- Fetch is eligible only in RUN, and only when FIFO count + in-flight reads < FIFO_DEPTH.
- Per-cycle decision:
  1. Fetch, if eligible and count <= LOW_WM (urgent).
  2. Otherwise a writer, chosen round-robin: the pointer flips to the other writer after each grant, and a lone requester always wins.
  3. Otherwise fetch, if eligible.
  4. Otherwise the port is idle.
- A writer whose `wr_gnt` is high this cycle is masked from this cycle's decision. This prevents a double grant before it drops `wr_req`.
- Read data is pushed into the FIFO on the edge ending the `mem_rdata`-valid cycle.
- `frame_start` with reads in flight: load a discard counter with the in-flight count. Returning words are dropped until it reaches 0.
- Concurrent pop and push with the FIFO full is legal: count is unchanged.
- Pop when empty: FIFO unchanged and `underflow` sets.
- `fetch_addr` never wraps. It stops at PIXELS-1 until the next `frame_start`.

## Timing
- Reset values:
  - State IDLE.
  - All strobes and `wr_gnt` = 0.
  - `mem_addr` and `mem_wdata` = 0.
  - FIFO empty, so `pix_valid` = 0 and `pix_data` = 0.
  - `underflow` = 0.
  - RR pointer on writer 0.
  - In-flight count and discard counter = 0.
- Decision in cycle t drives the registered `mem_*`/`wr_gnt` in cycle t+1. Read data is valid at t+2 and `pix_valid` rises at t+3 if the FIFO was empty.
- `frame_start` in cycle t: the first `mem_re` (addr 0) is in cycle t+2 at the earliest.
- Reset mid-operation clears everything at once. Any in-flight read data is ignored.
- Sustained throughput: one memory access per cycle.

## Structure
- The shared package `vga_pkg` holds:
  - The FSM state enum (IDLE/RUN/DONE).
  - The constants H_ACTIVE=640, V_ACTIVE=480, and PIXELS.
- Sub-module `vga_pix_fifo`: synchronous FIFO (DATA_W x FIFO_DEPTH) with count, push, pop, and a flush input.
- Arbitration, FSM and counters live in `vga_fb_arbiter`.

## Test plan
- Reset, then `frame_start`, no writers, pops held off: `mem_re` for addresses 0..7 starting at cycle t+2, then it stalls. FIFO count = 8 with no overfetch.
- Both writers request continuously, FIFO count 5, in RUN: grants alternate 0,1,0,1. A fetch is inserted once count <= 2.
- Writer 0 alone holds `wr_req` for 3 cycles: exactly one `wr_gnt[0]` pulse and one `mem_we` with `wr_addr0`/`wr_data0`. No second grant.
- `frame_start` with 2 reads in flight: those 2 returning words are discarded. The first pushed word comes from address 0.
- Fetch through PIXELS-1: state DONE and no further `mem_re`. Writers are granted every cycle.
- `pix_pop` while empty: `underflow`=1 and stays 1 until the next `frame_start` clears it.
